if_prefetch_queue: RTL
======================

# if_prefetch_queue

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and the decode stage. It keeps fetching ahead while decode is stalled. It handles branch/jump redirects, including delay-slot preservation and marking. Exception/interrupt and ERET redirects flush the queue. Fetch address errors are tagged so the CP0 logic downstream can raise AdEL precisely.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_3000, fetch PC after reset
- HANDLER, 32'h0000_4180, exception/interrupt vector
- ADDR_LO, 32'h0000_3000, lowest legal fetch address
- ADDR_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- imem_addr  out  32  current fetch PC (fpc) to combinational IM
- imem_rdata  in  32  IM word at imem_addr, same cycle
- redirect_br  in  1  taken branch/jump currently in D
- br_target  in  32  branch/jump target
- exc_req  in  1  interrupt or exception taken this cycle
- eret_req  in  1  ERET in D
- epc  in  32  return address for ERET
- d_ready  in  1  decode accepts head entry (0 = stall)
- d_valid  out  1  queue head valid
- d_instr  out  32  head instruction
- d_pc  out  32  head PC
- d_pc8  out  32  head PC + 8 (link value)
- d_bd  out  1  head is a branch delay slot
- d_exccode  out  5  5'd4 on fetch fault, else 0
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry fields: {pc, instr, bd, fault}. d_* show the head entry combinationally from storage. When empty, d_valid=0 and all other d_* are 0.
- Pop: d_valid && d_ready.
- Push: state≠HALT, no redirect this cycle, and (count<DEPTH or pop). Push stores fpc and imem_rdata, then sets fpc←fpc+4.
- Fault: fpc[1:0]≠0, fpc<ADDR_LO or fpc>ADDR_HI.
  - The entry is pushed with instr=0, fault=1.
  - State goes to HALT: no further fetch until a redirect.
- States:
  - RUN: normal fetch.
  - SLOT: the delay slot has not been fetched yet; saved target is held in tgt.
  - HALT: stopped after a fault.
- Redirect priority: exc_req > eret_req > redirect_br.
- exc_req: flush all entries, fpc←HANDLER, state→RUN. Any pending SLOT is dropped.
- eret_req: flush all entries, fpc←epc, state→RUN. No delay slot.
- redirect_br, head present and popped this cycle: the head is the delay slot and leaves. Flush the rest, fpc←br_target.
- redirect_br, head present and not popped: keep the head only and set its bd=1. Flush the rest, fpc←br_target.
- redirect_br, queue empty: tgt←br_target, state→SLOT, fpc unchanged.
- In SLOT, the next push carries bd=1; then fpc←tgt, state→RUN. A faulting slot fetch goes to HALT instead.
- In a redirect cycle no push occurs. A pop in that same cycle still completes.
- count is always 0..DEPTH. The head/tail pointers use log2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset (reset=0 at an edge): fpc=RESET_PC, state RUN, queue empty, count=0, d_valid=0, d_bd=0, d_exccode=0, tgt=0.
- Fetch-to-decode latency is 1 cycle. The word pushed at edge N is visible on d_* after edge N, even if the queue was empty before.
- Redirect at edge N: the first target fetch happens in cycle N+1; d_valid for the target comes after edge N+1.
- Full with d_ready=0: fpc holds and imem_addr is stable. Full with d_ready=1: push and pop happen in the same cycle, and count stays DEPTH.
- Reset asserted mid-SLOT or mid-HALT returns to the reset state at that edge.
- exc_req together with redirect_br or eret_req: only exc_req takes effect.

## Test plan
- Reset release with d_ready=1: imem_addr=0x3000, 0x3004, …. d_pc follows one cycle later, count stays at 1, d_bd=0.
- d_ready=0 for 8 cycles (DEPTH=4): count reaches 4 and fpc freezes at 0x3010. Raising d_ready drains 0x3000..0x300C in order while refill continues.
- Queue holds 0x3008..0x3014 with d_ready=0, redirect_br to 0x3400: count→1, head 0x3008 with d_bd=1. The next entries are 0x3400, 0x3404.
- Queue empty, redirect_br to 0x3500: state SLOT. The next push is fpc with bd=1, followed by 0x3500.
- redirect_br to 0x3002: entry d_pc=0x3002, d_instr=0, d_exccode=4. No further pushes until exc_req, which gives next d_pc=0x4180.
- exc_req and eret_req asserted together with a full queue: the queue flushes and the next d_pc=0x4180. A later lone eret_req with epc=0x3020 gives next d_pc=0x3020 with d_bd=0.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bus: instruction-memory port, redirect controls and the decode-side
// view of the prefetch queue head. The fetch stage uses "master", its environment "slave".
interface if_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_br;
  logic [31:0]   br_target;
  logic          exc_req;
  logic          eret_req;
  logic [31:0]   epc;
  logic          d_ready;
  logic          d_valid;
  logic [31:0]   d_instr;
  logic [31:0]   d_pc;
  logic [31:0]   d_pc8;
  logic          d_bd;
  logic [4:0]    d_exccode;
  logic [CW-1:0] count;

  modport master (
    output imem_addr, d_valid, d_instr, d_pc, d_pc8, d_bd, d_exccode, count,
    input  imem_rdata, redirect_br, br_target, exc_req, eret_req, epc, d_ready
  );

  modport slave (
    input  imem_addr, d_valid, d_instr, d_pc, d_pc8, d_bd, d_exccode, count,
    output imem_rdata, redirect_br, br_target, exc_req, eret_req, epc, d_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue feeding decode.
// Handles branch delay slots, exception/ERET flushes and tags fetch address faults.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] HANDLER  = 32'h0000_4180,
  parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_6FFC
) (
  input logic               clk,
  input logic               reset,
  if_prefetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SLOT = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fpc, fpc_n;
  logic [31:0]   tgt, tgt_n;
  logic [PW-1:0] head, head_n;
  logic [PW-1:0] tail, tail_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [31:0]    q_pc    [DEPTH];
  logic [31:0]    q_instr [DEPTH];
  logic [DEPTH-1:0] q_bd;
  logic [DEPTH-1:0] q_fault;

  logic valid;
  logic pop;
  logic push;
  logic fault;
  logic redirect;
  logic mark_bd;

  assign valid    = (cnt != '0);
  assign pop      = valid && bus.d_ready;
  assign redirect = bus.exc_req || bus.eret_req || bus.redirect_br;
  assign fault    = (fpc[1:0] != 2'b00) || (fpc < ADDR_LO) || (fpc > ADDR_HI);
  assign push     = (state != HALT) && !redirect && ((cnt < FULL) || pop);

  // Redirect priority is exc > eret > branch; a branch keeps the unpopped head as its delay slot.
  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    tgt_n   = tgt;
    head_n  = head;
    tail_n  = tail;
    cnt_n   = cnt;
    mark_bd = 1'b0;
    if (bus.exc_req) begin
      head_n  = tail;
      cnt_n   = '0;
      fpc_n   = HANDLER;
      state_n = RUN;
    end else if (bus.eret_req) begin
      head_n  = tail;
      cnt_n   = '0;
      fpc_n   = bus.epc;
      state_n = RUN;
    end else if (bus.redirect_br) begin
      if (!valid) begin
        tgt_n   = bus.br_target;
        state_n = SLOT;
      end else if (pop) begin
        head_n  = tail;
        cnt_n   = '0;
        fpc_n   = bus.br_target;
        state_n = RUN;
      end else begin
        tail_n  = head + PW'(1);
        cnt_n   = CW'(1);
        mark_bd = 1'b1;
        fpc_n   = bus.br_target;
        state_n = RUN;
      end
    end else begin
      if (push) begin
        tail_n = tail + PW'(1);
        fpc_n  = fpc + 32'd4;
        if (fault) begin
          state_n = HALT;
        end else if (state == SLOT) begin
          fpc_n   = tgt;
          state_n = RUN;
        end
      end
      if (pop) begin
        head_n = head + PW'(1);
      end
      cnt_n = cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      fpc   <= RESET_PC;
      tgt   <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      tgt   <= tgt_n;
      head  <= head_n;
      tail  <= tail_n;
      cnt   <= cnt_n;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= fpc;
      q_instr[tail] <= fault ? 32'd0 : bus.imem_rdata;
      q_bd[tail]    <= (state == SLOT);
      q_fault[tail] <= fault;
    end
    if (mark_bd) begin
      q_bd[head] <= 1'b1;
    end
  end

  assign bus.imem_addr = fpc;
  assign bus.count     = cnt;
  assign bus.d_valid   = valid;
  assign bus.d_pc      = valid ? q_pc[head] : 32'd0;
  assign bus.d_pc8     = valid ? (q_pc[head] + 32'd8) : 32'd0;
  assign bus.d_instr   = valid ? q_instr[head] : 32'd0;
  assign bus.d_bd      = valid && q_bd[head];
  assign bus.d_exccode = (valid && q_fault[head]) ? 5'd4 : 5'd0;
endmodule
